// File: rtl/vdg_vram_arbiter.sv
// -----------------------------------------------------------------------------
// vdg_vram_arbiter
//
// Shares one 8-bit video RAM between the host CPU and the MC6847X display
// fetch. A `preload` pulse from FrameTiming starts a strict-priority burst that
// streams one display row (BYTES_PER_ROW bytes) out on vd/vd_valid/da. CPU
// read/write requests are served in the idle gaps between bursts.
//
// RAM timing model: ram_addr/ram_we/ram_wdata are registered. The RAM returns
// ram_rdata for the presented address in time to be captured on the next
// clock edge, so a byte is captured one edge after its address is issued.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   fsn                   field sync (active low); a falling edge reloads the
//                         row base and aborts a running burst
//   preload, rowclear     one-cycle pulses from FrameTiming
//   graphics              1 = advance row every burst, 0 = alpha mode
//   cpu_req/we/addr/wdata CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata    one-cycle completion pulse and read data
//   ram_addr/we/wdata     RAM command, ram_rdata RAM read data
//   vd, vd_valid, da      display byte, strobe, and its RAM address
//   overrun               sticky: preload arrived while a burst was running
//
// Optional feature macro: VDG_ARB_CPU_SLOT_EN
//   When defined, a waiting CPU request is slotted into the burst after every
//   8th display address (CPU_ISSUE/CPU_DONE, then FETCH resumes).
//   When undefined, the CPU waits for the whole burst.
// -----------------------------------------------------------------------------
module vdg_vram_arbiter #(
    parameter int ADDR_W        = 13,
    parameter int BYTES_PER_ROW = 32,
    parameter int VRAM_BASE     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fsn,
    input  logic              preload,
    input  logic              rowclear,
    input  logic              graphics,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        vd,
    output logic              vd_valid,
    output logic [ADDR_W-1:0] da,
    output logic              overrun
);

    localparam int CNT_W = $clog2(BYTES_PER_ROW + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BYTES_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(VRAM_BASE);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(BYTES_PER_ROW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_CPU_ISSUE,
        S_CPU_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [CNT_W-1:0]  r_fetch_cnt;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_fsn_d;
    logic              r_fetch_d;       // a display address was issued last edge
    logic              r_preload_pend;  // preload seen during a CPU access
    logic              r_rowclear_pend; // rowclear seen since the last advance
    logic              r_slot_ret;      // CPU slot taken mid-burst, resume FETCH

    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [7:0]        r_ram_wdata;
    logic              r_cpu_ack;
    logic [7:0]        r_cpu_rdata;
    logic [7:0]        r_vd;
    logic              r_vd_valid;
    logic [ADDR_W-1:0] r_da;
    logic              r_overrun;

    logic w_fsn_fall;
    logic w_preload_go;
    logic w_abort;
    logic w_start_burst;
    logic w_issue_disp;
    logic w_issue_cpu;
    logic w_cpu_done;
    logic w_advance;
    logic w_slot_take;
    logic w_in_burst;
    logic w_in_cpu;

    assign w_fsn_fall   = r_fsn_d & ~fsn;
    assign w_preload_go = preload | r_preload_pend;
    assign w_in_cpu     = (r_state == S_CPU_ISSUE) || (r_state == S_CPU_DONE);
    // A CPU slot inside a burst still counts as "burst running" for overrun.
    assign w_in_burst   = (r_state == S_FETCH) || (r_state == S_DRAIN) || r_slot_ret;
    assign w_abort      = w_fsn_fall && ((r_state == S_FETCH) || (r_state == S_DRAIN));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and per-cycle control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_start_burst = 1'b0;
        w_issue_disp  = 1'b0;
        w_issue_cpu   = 1'b0;
        w_cpu_done    = 1'b0;
        w_advance     = 1'b0;
        w_slot_take   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_preload_go) begin
                    w_state_next  = S_FETCH;
                    w_start_burst = 1'b1;
                end else if (cpu_req) begin
                    w_state_next = S_CPU_ISSUE;
                end
            end
            S_FETCH: begin
                w_issue_disp = 1'b1;
                if (r_fetch_cnt == LAST_CNT) begin
                    w_state_next = S_DRAIN;
                end
`ifdef VDG_ARB_CPU_SLOT_EN
                else if (((r_fetch_cnt & CNT_W'(7)) == CNT_W'(7)) && cpu_req) begin
                    w_state_next = S_CPU_ISSUE;
                    w_slot_take  = 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                w_advance    = 1'b1;
                w_state_next = S_IDLE;
            end
            S_CPU_ISSUE: begin
                w_issue_cpu  = 1'b1;
                w_state_next = S_CPU_DONE;
            end
            S_CPU_DONE: begin
                w_cpu_done = 1'b1;
                if (r_slot_ret && !w_fsn_fall) begin
                    w_state_next = S_FETCH;
                end else if (w_preload_go && !r_slot_ret) begin
                    // Latched preload starts the burst with no IDLE gap.
                    w_state_next  = S_FETCH;
                    w_start_burst = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Field sync kills a burst outright; CPU accesses are left to finish.
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_issue_disp = 1'b0;
            w_advance    = 1'b0;
            w_slot_take  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt     <= '0;
            r_row_base      <= BASE_ADDR;
            r_fsn_d         <= 1'b0;
            r_fetch_d       <= 1'b0;
            r_preload_pend  <= 1'b0;
            r_rowclear_pend <= 1'b0;
            r_slot_ret      <= 1'b0;
            r_ram_addr      <= '0;
            r_ram_we        <= 1'b0;
            r_ram_wdata     <= '0;
            r_cpu_ack       <= 1'b0;
            r_cpu_rdata     <= '0;
            r_vd            <= '0;
            r_vd_valid      <= 1'b0;
            r_da            <= '0;
            r_overrun       <= 1'b0;
        end else begin
            r_fsn_d    <= fsn;
            r_ram_we   <= 1'b0;
            r_fetch_d  <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_vd_valid <= 1'b0;

            if (w_start_burst) begin
                r_fetch_cnt <= '0;
            end

            if (w_issue_disp) begin
                r_ram_addr  <= r_row_base + ADDR_W'(r_fetch_cnt);
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
                r_fetch_d   <= 1'b1;
            end

            if (w_issue_cpu) begin
                r_ram_addr <= cpu_addr;
                r_ram_we   <= cpu_we;
                if (cpu_we) begin
                    r_ram_wdata <= cpu_wdata;
                end
            end

            // ram_we is still high during CPU_DONE for a write access.
            if (w_cpu_done) begin
                r_cpu_ack <= 1'b1;
                if (!r_ram_we) begin
                    r_cpu_rdata <= ram_rdata;
                end
            end

            // Capture the byte for the address issued on the previous edge.
            if (r_fetch_d && !w_fsn_fall) begin
                r_vd       <= ram_rdata;
                r_da       <= r_ram_addr;
                r_vd_valid <= 1'b1;
            end

            // Row advance; rowclear is remembered until an alpha advance uses it.
            if (w_advance && graphics) begin
                r_row_base      <= r_row_base + ROW_STEP;
                r_rowclear_pend <= r_rowclear_pend | rowclear;
            end else if (w_advance && (r_rowclear_pend || rowclear)) begin
                r_row_base      <= r_row_base + ROW_STEP;
                r_rowclear_pend <= 1'b0;
            end else if (rowclear) begin
                r_rowclear_pend <= 1'b1;
            end

            if (w_fsn_fall) begin
                r_row_base <= BASE_ADDR;
            end

            if (w_start_burst) begin
                r_preload_pend <= 1'b0;
            end else if (preload && w_in_cpu && !r_slot_ret) begin
                r_preload_pend <= 1'b1;
            end

            if (w_slot_take) begin
                r_slot_ret <= 1'b1;
            end else if (w_cpu_done || w_fsn_fall) begin
                r_slot_ret <= 1'b0;
            end

            if (preload && w_in_burst) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign vd        = r_vd;
    assign vd_valid  = r_vd_valid;
    assign da        = r_da;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_vdg_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vdg_vram_arbiter
//
// Directed bench for vdg_vram_arbiter (default build, CPU slot feature off).
// A behavioural 8 KiB RAM holds RAM[i] = i[7:0] after reset; it returns the
// byte at ram_addr combinationally so it is captured on the next edge, and
// writes on the clock edge while ram_we is high.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_vdg_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fsn;
    logic        preload;
    logic        rowclear;
    logic        graphics;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  vd;
    logic        vd_valid;
    logic [12:0] da;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [0:8191];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    assign ram_rdata = mem[ram_addr];

    vdg_vram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .fsn       (fsn),
        .preload   (preload),
        .rowclear  (rowclear),
        .graphics  (graphics),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .vd        (vd),
        .vd_valid  (vd_valid),
        .da        (da),
        .overrun   (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // preload sampled at edge T; address at T+1; 32 bytes at T+2..T+33;
    // vd_valid low again at T+34. Optional stray preload in the middle.
    task automatic do_burst(input logic [12:0] base, input bit mid_pre);
        logic [12:0] a;
        int          bad;
        bad = n_err;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        check("first_addr", 32'(ram_addr), 32'(base));
        for (int k = 0; k < 32; k++) begin
            if (mid_pre && k == 5) preload = 1'b1;
            tick();
            preload = 1'b0;
            a = base + 13'(k);
            check("vd_valid", 32'(vd_valid), 32'd1);
            check("vd", 32'(vd), 32'(a[7:0]));
            check("da", 32'(da), 32'(a));
        end
        tick();
        check("vd_valid_end", 32'(vd_valid), 32'd0);
        $display("burst base=%04h stray_preload=%0d errors=%0d", base, mid_pre, n_err - bad);
    endtask

    task automatic quiet_burst();
        preload = 1'b1;
        tick();
        preload = 1'b0;
        for (int k = 0; k < 35; k++) tick();
    endtask

    initial begin
        rst = 1'b1; fsn = 1'b1; preload = 1'b0; rowclear = 1'b0; graphics = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // ---- reset state
        tick(); tick(); tick();
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_vd_valid", 32'(vd_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_vd", 32'(vd), 32'd0);
        check("rst_da", 32'(da), 32'd0);
        $display("reset checked");
        rst = 1'b0;
        tick(); tick();

        // ---- graphics mode: three consecutive rows
        do_burst(13'h0000, 1'b0);
        tick();
        do_burst(13'h0020, 1'b0);
        do_burst(13'h0040, 1'b0);

        // ---- field sync in IDLE reloads the base; switch to alpha mode
        fsn = 1'b0; tick(); fsn = 1'b1; tick();
        graphics = 1'b0;
        do_burst(13'h0000, 1'b0);
        do_burst(13'h0000, 1'b0);
        rowclear = 1'b1; tick(); rowclear = 1'b0; tick();
        do_burst(13'h0000, 1'b0);
        do_burst(13'h0020, 1'b0);

        // ---- CPU write 0xA5 @0x0100
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'hA5;
        tick();
        tick();
        check("wr_addr", 32'(ram_addr), 32'h0100);
        check("wr_we", 32'(ram_we), 32'd1);
        check("wr_wdata", 32'(ram_wdata), 32'hA5);
        check("wr_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        check("wr_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check("wr_ack_pulse", 32'(cpu_ack), 32'd0);
        $display("cpu write addr=0100 data=a5");

        // ---- CPU read @0x0100
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        tick();
        tick();
        check("rd_addr", 32'(ram_addr), 32'h0100);
        check("rd_we", 32'(ram_we), 32'd0);
        tick();
        check("rd_ack", 32'(cpu_ack), 32'd1);
        check("rd_data", 32'(cpu_rdata), 32'hA5);
        cpu_req = 1'b0;
        tick();
        $display("cpu read addr=0100 data=%02h", cpu_rdata);

        // ---- CPU request and preload together: burst wins, ack 2 cycles after
        graphics = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
        do_burst(13'h0020, 1'b0);
        tick();
        check("coll_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        check("coll_ack", 32'(cpu_ack), 32'd1);
        check("coll_rdata", 32'(cpu_rdata), 32'h05);
        cpu_req = 1'b0;
        tick();
        $display("cpu read after burst addr=0005 data=%02h", cpu_rdata);

        // ---- field sync falls during fetch 10: burst aborted, base reloaded
        preload = 1'b1; tick(); preload = 1'b0;
        tick();
        check("abort_first_addr", 32'(ram_addr), 32'h0040);
        for (int k = 0; k < 9; k++) begin
            tick();
            check("abort_vd", 32'(vd), 32'(8'h40 + 8'(k)));
            check("abort_vd_valid", 32'(vd_valid), 32'd1);
        end
        fsn = 1'b0;
        tick();
        check("abort_stop0", 32'(vd_valid), 32'd0);
        tick();
        check("abort_stop1", 32'(vd_valid), 32'd0);
        fsn = 1'b1;
        tick();
        check("abort_stop2", 32'(vd_valid), 32'd0);
        $display("field sync abort at fetch 10");
        do_burst(13'h0000, 1'b0);

        // ---- stray preload mid-burst: overrun, burst length unchanged
        check("overrun_before", 32'(overrun), 32'd0);
        do_burst(13'h0020, 1'b1);
        check("overrun_after", 32'(overrun), 32'd1);

        // ---- walk the row base up to the top of VRAM, then wrap
        for (int b = 0; b < 253; b++) quiet_burst();
        $display("advanced 253 rows without checks");
        do_burst(13'h1FE0, 1'b0);
        do_burst(13'h0000, 1'b0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // ---- reset in the middle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h3C;
        tick();
        tick();
        check("rstcpu_we", 32'(ram_we), 32'd1);
        rst = 1'b1;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("rstcpu_ack", 32'(cpu_ack), 32'd0);
        check("rstcpu_ram_we", 32'(ram_we), 32'd0);
        check("rstcpu_ram_addr", 32'(ram_addr), 32'd0);
        check("rstcpu_wdata", 32'(ram_wdata), 32'd0);
        check("rstcpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rstcpu_vd", 32'(vd), 32'd0);
        check("rstcpu_da", 32'(da), 32'd0);
        check("rstcpu_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();
        check("rstcpu_no_ack0", 32'(cpu_ack), 32'd0);
        tick();
        check("rstcpu_no_ack1", 32'(cpu_ack), 32'd0);
        $display("reset during cpu write");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
